world_engine: RTL and testbench

//  Parametrised world simulator for the pipe-cleaning robot. Holds a ROWS x COLS cell map and
//  the robot pose, generates the divided robot clock, derives head/left/under/barrier sensors,

---
 rtl/world_engine_if.sv | 49 ++++
 rtl/world_engine.sv | 211 +++++++++++++++++++++
 tb/tb_world_engine.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/world_engine_if.sv
// World engine bus: map load port, start pose, run/command inputs, sensors,
// pose, graphics read port and statistics. The engine sits on the slave side;
// the robot/loader/graphics side uses the master modport.
interface world_engine_if #(
  parameter int ROWS = 10,
  parameter int COLS = 20
);
  localparam int AW = $clog2(ROWS * COLS);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [2:0]    load_data;
  logic [RW-1:0] init_row;
  logic [CW-1:0] init_col;
  logic [1:0]    init_orient;
  logic          start;
  logic          run;
  logic          front;
  logic          turn;
  logic          remove;
  logic          robot_clock;
  logic          head;
  logic          left;
  logic          under;
  logic          barrier;
  logic [RW-1:0] robot_row;
  logic [CW-1:0] robot_col;
  logic [1:0]    robot_orient;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data;
  logic          bump;
  logic [15:0]   step_count;

  modport master (
    output load_we, load_addr, load_data, init_row, init_col, init_orient,
           start, run, front, turn, remove, rd_addr,
    input  robot_clock, head, left, under, barrier, robot_row, robot_col,
           robot_orient, rd_data, bump, step_count
  );

  modport slave (
    input  load_we, load_addr, load_data, init_row, init_col, init_orient,
           start, run, front, turn, remove, rd_addr,
    output robot_clock, head, left, under, barrier, robot_row, robot_col,
           robot_orient, rd_data, bump, step_count
  );
endinterface

// File: rtl/world_engine.sv
// World simulator for the pipe-cleaning robot: cell map, robot pose, divided
// robot clock, sensor derivation, command execution and a graphics read port.
// robot_clock is high for STEP_DIV cycles and low for STEP_DIV cycles; the
// last low cycle is the SENSE cycle, so a free-running period is 2*STEP_DIV.
module world_engine #(
  parameter int ROWS         = 10,
  parameter int COLS         = 20,
  parameter int STEP_DIV     = 4,
  parameter int REMOVE_TICKS = 3
) (
  input  logic          clock,
  input  logic          reset,
  world_engine_if.slave bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int DW    = $clog2(STEP_DIV);
  localparam int RCW   = $clog2(REMOVE_TICKS + 1);

  localparam logic [RW:0] ONE_R   = (RW+1)'(1);
  localparam logic [CW:0] ONE_C   = (CW+1)'(1);
  localparam logic [RW:0] ROWS_W  = (RW+1)'(ROWS);
  localparam logic [CW:0] COLS_W  = (CW+1)'(COLS);
  localparam logic [AW:0] CELLS_W = (AW+1)'(CELLS);

  typedef enum logic [1:0] {S_LOAD, S_SENSE, S_HIGH, S_LOW} state_t;
  typedef enum logic [1:0] {DIR_N = 2'b00, DIR_S = 2'b01, DIR_E = 2'b10, DIR_W = 2'b11} dir_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt;

  logic [2:0]     map_q [CELLS];
  logic [RW-1:0]  row_q;
  logic [CW-1:0]  col_q;
  dir_t           orient_q;
  logic [RCW-1:0] rem_cnt;
  logic [15:0]    steps_q;
  logic           bump_q, rclk_q, head_q, left_q, under_q, barrier_q;
  logic [2:0]     rd_q;

  // Geometry around the pose the next sensor sample or command will use.
  logic [RW:0]   s_row, a_row, l_row;
  logic [CW:0]   s_col, a_col, l_col;
  dir_t          s_orient;
  logic          a_ok, l_ok, p_ok;
  logic [AW-1:0] a_addr, l_addr, p_addr;
  logic [2:0]    a_code, l_code, p_code;
  logic          head_nx, left_nx, under_nx, barrier_nx;
  logic          hi_entry, moved, clear_cell;

  function automatic logic [AW-1:0] cell_addr(input logic [RW:0] r, input logic [CW:0] c);
    return AW'(int'(r) * COLS + int'(c));
  endfunction

  function automatic dir_t turn_left(input dir_t d);
    case (d)
      DIR_N:   return DIR_W;
      DIR_W:   return DIR_S;
      DIR_S:   return DIR_E;
      default: return DIR_N;
    endcase
  endfunction

  // State register and phase counter; the counter restarts on every state change.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_LOAD;
      div_cnt <= '0;
    end else begin
      state   <= state_nx;
      div_cnt <= (state_nx != state) ? '0 : div_cnt + DW'(1);
    end
  end

  // Next-state logic: LOAD -> SENSE -> HIGH -> LOW -> SENSE.
  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (bus.start) state_nx = S_SENSE;
      S_SENSE: if (bus.run) state_nx = S_HIGH;
      S_HIGH:  if (div_cnt == DW'(STEP_DIV - 1)) state_nx = S_LOW;
      default: if (div_cnt == DW'(STEP_DIV - 2)) state_nx = S_SENSE;
    endcase
  end

  // Ahead/left/under cells; out-of-bounds neighbours never touch the map.
  always_comb begin
    s_row    = (state == S_LOAD) ? {1'b0, bus.init_row} : {1'b0, row_q};
    s_col    = (state == S_LOAD) ? {1'b0, bus.init_col} : {1'b0, col_q};
    s_orient = (state == S_LOAD) ? dir_t'(bus.init_orient) : orient_q;
    a_row = s_row;
    a_col = s_col;
    l_row = s_row;
    l_col = s_col;
    case (s_orient)
      DIR_N: begin a_row = s_row - ONE_R; l_col = s_col - ONE_C; end
      DIR_S: begin a_row = s_row + ONE_R; l_col = s_col + ONE_C; end
      DIR_E: begin a_col = s_col + ONE_C; l_row = s_row - ONE_R; end
      default: begin a_col = s_col - ONE_C; l_row = s_row + ONE_R; end
    endcase
    // Underflow wraps to all-ones in the widened field, which is >= ROWS/COLS.
    a_ok   = (a_row < ROWS_W) && (a_col < COLS_W);
    l_ok   = (l_row < ROWS_W) && (l_col < COLS_W);
    p_ok   = (s_row < ROWS_W) && (s_col < COLS_W);
    a_addr = a_ok ? cell_addr(a_row, a_col) : '0;
    l_addr = l_ok ? cell_addr(l_row, l_col) : '0;
    p_addr = p_ok ? cell_addr(s_row, s_col) : '0;
    a_code = map_q[a_addr];
    l_code = map_q[l_addr];
    p_code = map_q[p_addr];
    head_nx    = !a_ok || (a_code == 3'd1);
    left_nx    = !l_ok || (l_code == 3'd1);
    under_nx   = p_ok && (p_code == 3'd7);
    barrier_nx = a_ok && (a_code == 3'd2);
    hi_entry   = (state == S_SENSE) && bus.run;
    moved      = bus.front ? !(head_nx || barrier_nx) : bus.turn;
    clear_cell = hi_entry && bus.remove && barrier_nx &&
                 (rem_cnt >= RCW'(REMOVE_TICKS - 1));
  end

  // Map storage: loader writes in LOAD, barrier clears while running.
  // NOTE: the map has no reset; it is a storage array whose contents come from the loader.
  always_ff @(posedge clock) begin
    if (state == S_LOAD && bus.load_we && ({1'b0, bus.load_addr} < CELLS_W))
      map_q[bus.load_addr] <= bus.load_data;
    else if (clear_cell)
      map_q[a_addr] <= 3'd0;
  end

  // Graphics read port, one cycle latency, valid in every state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rd_q <= 3'd0;
    else
      rd_q <= ({1'b0, bus.rd_addr} < CELLS_W) ? map_q[bus.rd_addr] : 3'd0;
  end

  // Robot clock is high exactly while the FSM is in HIGH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rclk_q <= 1'b0;
    else
      rclk_q <= (state_nx == S_HIGH);
  end

  // Sensors are sampled on every edge that lands in SENSE and held otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q    <= 1'b0;
      left_q    <= 1'b0;
      under_q   <= 1'b0;
      barrier_q <= 1'b0;
    end else if (state_nx == S_SENSE) begin
      head_q    <= head_nx;
      left_q    <= left_nx;
      under_q   <= under_nx;
      barrier_q <= barrier_nx;
    end
  end

  // Pose, bump, tick counter and remove streak: latched on start, updated on HIGH entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q    <= '0;
      col_q    <= '0;
      orient_q <= DIR_N;
      bump_q   <= 1'b0;
      steps_q  <= 16'd0;
      rem_cnt  <= '0;
    end else if (state == S_LOAD && bus.start) begin
      row_q    <= bus.init_row;
      col_q    <= bus.init_col;
      orient_q <= dir_t'(bus.init_orient);
      bump_q   <= 1'b0;
      steps_q  <= 16'd0;
      rem_cnt  <= '0;
    end else if (hi_entry) begin
      if (steps_q != 16'hFFFF) steps_q <= steps_q + 16'd1;
      if (bus.front) begin
        if (head_nx || barrier_nx) begin
          bump_q <= 1'b1;
        end else begin
          row_q <= a_row[RW-1:0];
          col_q <= a_col[CW-1:0];
        end
      end else if (bus.turn) begin
        orient_q <= turn_left(orient_q);
      end
      if (!bus.remove || moved || clear_cell)
        rem_cnt <= '0;
      else if (rem_cnt != RCW'(REMOVE_TICKS))
        rem_cnt <= rem_cnt + RCW'(1);
    end
  end

  assign bus.robot_clock  = rclk_q;
  assign bus.head         = head_q;
  assign bus.left         = left_q;
  assign bus.under        = under_q;
  assign bus.barrier      = barrier_q;
  assign bus.robot_row    = row_q;
  assign bus.robot_col    = col_q;
  assign bus.robot_orient = orient_q;
  assign bus.rd_data      = rd_q;
  assign bus.bump         = bump_q;
  assign bus.step_count   = steps_q;
endmodule

// File: tb/tb_world_engine.sv
// Testbench for world_engine: directed scenarios plus random maps/commands.
// The driver predicts each robot tick from a cell-level world model and
// queues the expectation; the monitor compares at each robot_clock fall.
module tb_world_engine;
  localparam int ROWS = 10, COLS = 20, STEP_DIV = 4, REMOVE_TICKS = 3;
  localparam int AW = $clog2(ROWS * COLS), RW = $clog2(ROWS), CW = $clog2(COLS);
  localparam int LIM = 200;
  localparam int ADR[4]   = '{-1, 1, 0, 0};
  localparam int ADC[4]   = '{0, 0, 1, -1};
  localparam int LDR[4]   = '{0, 0, -1, 1};
  localparam int LDC[4]   = '{-1, 1, 0, 0};
  localparam int LTURN[4] = '{3, 2, 0, 1};

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  c;
    logic [1:0]  o;
    logic        h, l, u, b, bump;
    logic [15:0] steps;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  world_engine_if #(.ROWS(ROWS), .COLS(COLS)) bus();

  world_engine #(.ROWS(ROWS), .COLS(COLS), .STEP_DIV(STEP_DIV), .REMOVE_TICKS(REMOVE_TICKS))
    dut (.clock(clock), .reset(reset), .bus(bus));

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 0;
  obs_t exp_q[$];

  int m_map[ROWS][COLS];
  int m_r, m_c, m_o, m_rem, m_steps;
  bit m_bump;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int code_at(input int r, input int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return -1;
    return m_map[r][c];
  endfunction

  // Monitor: every robot_clock fall presents one completed tick.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge bus.robot_clock);
      #1;
      if (mon_en) begin
        a = {8'(bus.robot_row), 8'(bus.robot_col), bus.robot_orient, bus.head, bus.left,
             bus.under, bus.barrier, bus.bump, bus.step_count};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: actual=%0h required=none", a);
        end else begin
          e = exp_q.pop_front();
          check("sb_tick", a, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic reset_dut();
    reset = 1'b0;
    bus.load_we = 0; bus.load_addr = '0; bus.load_data = '0;
    bus.init_row = '0; bus.init_col = '0; bus.init_orient = '0;
    bus.start = 0; bus.run = 0; bus.front = 0; bus.turn = 0; bus.remove = 0;
    bus.rd_addr = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_map[r][c] = 0;
  endtask

  task automatic load_map();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        bus.load_we   = 1;
        bus.load_addr = AW'(r * COLS + c);
        bus.load_data = 3'(m_map[r][c]);
        @(posedge clock);
        #1;
      end
    bus.load_we = 0;
  endtask

  task automatic do_start(input int r, input int c, input int o);
    m_r = r; m_c = c; m_o = o; m_bump = 0; m_steps = 0; m_rem = 0;
    bus.init_row = RW'(r); bus.init_col = CW'(c); bus.init_orient = 2'(o);
    bus.run = 1; bus.start = 1;
    @(posedge clock);
    #1 bus.start = 0;
  endtask

  task automatic wait_fall();
    int n;
    n = 0;
    while (bus.robot_clock !== 1'b1 && n < LIM) begin @(posedge clock); #1; n++; end
    while (bus.robot_clock !== 1'b0 && n < LIM) begin @(posedge clock); #1; n++; end
    check("tick_done", (n < LIM), 1);
  endtask

  // One robot tick: predict sensors seen, apply the command rules, queue result.
  task automatic tick(input bit f, input bit t, input bit rm);
    obs_t e;
    int   ar, ac, acode, lcode;
    bit   moved;
    moved = 0;
    bus.front = f; bus.turn = t; bus.remove = rm;
    ar = m_r + ADR[m_o];
    ac = m_c + ADC[m_o];
    acode = code_at(ar, ac);
    lcode = code_at(m_r + LDR[m_o], m_c + LDC[m_o]);
    e.h = (acode == -1 || acode == 1);
    e.l = (lcode == -1 || lcode == 1);
    e.u = (code_at(m_r, m_c) == 7);
    e.b = (acode == 2);
    if (m_steps < 65535) m_steps++;
    if (rm) begin
      m_rem++;
      if (m_rem >= REMOVE_TICKS && acode == 2) begin
        m_map[ar][ac] = 0;
        m_rem = 0;
      end
    end else m_rem = 0;
    if (f) begin
      if (e.h || e.b) m_bump = 1;
      else begin m_r = ar; m_c = ac; moved = 1; end
    end else if (t) begin
      m_o = LTURN[m_o];
      moved = 1;
    end
    if (moved) m_rem = 0;
    e.r = 8'(m_r); e.c = 8'(m_c); e.o = 2'(m_o); e.bump = m_bump; e.steps = 16'(m_steps);
    exp_q.push_back(e);
    wait_fall();
  endtask

  task automatic end_sb();
    bus.front = 0; bus.turn = 0; bus.remove = 0;
    #2 mon_en = 0;
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic read_cell_check(input string nm, input int r, input int c);
    bus.rd_addr = AW'(r * COLS + c);
    @(posedge clock);
    #1 check(nm, bus.rd_data, m_map[r][c]);
  endtask

  task automatic read_map_check(input string nm);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) read_cell_check(nm, r, c);
  endtask

  task automatic begin_scn(input int r, input int c, input int o);
    reset_dut();
    load_map();
    do_start(r, c, o);
    mon_en = 1;
  endtask

  task automatic measure_period(output int p);
    int   first;
    logic prev;
    p = -1; first = -1; prev = bus.robot_clock;
    for (int n = 1; n <= LIM; n++) begin
      @(posedge clock);
      #1;
      if (!prev && bus.robot_clock) begin
        if (first < 0) first = n;
        else begin p = n - first; break; end
      end
      prev = bus.robot_clock;
    end
  endtask

  task automatic count_edges(input int cycles, output int rises, output int falls);
    logic prev;
    rises = 0; falls = 0; prev = bus.robot_clock;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      if (!prev && bus.robot_clock) rises++;
      if (prev && !bus.robot_clock) falls++;
      prev = bus.robot_clock;
    end
  endtask

  initial begin
    int p, rises, falls, n;
    // Reset values while reset is held.
    bus.rd_addr = '0;
    #1;
    check("reset_outputs", {bus.robot_clock, bus.head, bus.left, bus.under, bus.barrier,
          bus.bump, bus.step_count, bus.rd_data, bus.robot_row, bus.robot_col,
          bus.robot_orient}, 0);

    // Corner start on an empty map, then a left turn.
    clear_model();
    begin_scn(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    end_sb();

    // Three steps east.
    clear_model();
    begin_scn(5, 5, 2);
    repeat (3) tick(1, 0, 0);
    end_sb();

    // Wall ahead: bump without moving, then turn north.
    clear_model();
    m_map[5][6] = 1;
    begin_scn(5, 5, 2);
    tick(1, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    end_sb();

    // Barrier cleared by three consecutive removes.
    clear_model();
    m_map[4][5] = 2;
    begin_scn(5, 5, 0);
    repeat (3) tick(0, 0, 1);
    tick(0, 0, 0);
    end_sb();
    read_map_check("map_after_clear");

    // Interrupted remove streaks leave the barrier; front into it bumps.
    clear_model();
    m_map[4][5] = 2;
    begin_scn(5, 5, 0);
    repeat (2) tick(0, 0, 1);
    tick(0, 0, 0);
    repeat (2) tick(0, 0, 1);
    tick(1, 0, 0);
    end_sb();
    read_cell_check("barrier_kept", 4, 5);

    // South-east corner facing south, standing on dirt.
    clear_model();
    m_map[9][19] = 7;
    begin_scn(9, 19, 1);
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    end_sb();

    // Clock period, ignored start, pause, and reset while high.
    clear_model();
    reset_dut();
    load_map();
    do_start(3, 4, 2);
    measure_period(p);
    check("clock_period", p, 2 * STEP_DIV);
    bus.init_row = '0; bus.init_col = '0; bus.init_orient = '0;
    bus.start = 1;
    @(posedge clock);
    #1 bus.start = 0;
    check("start_ignored_pose", {bus.robot_row, bus.robot_col, bus.robot_orient},
          {RW'(3), CW'(4), 2'd2});
    check("start_ignored_steps", bus.step_count, 2);
    bus.run = 0;
    count_edges(4 * STEP_DIV, rises, falls);
    check("pause_falls", falls, 1);
    check("pause_rises", rises, 0);
    check("pause_steps", bus.step_count, 2);
    bus.run = 1;
    n = 0;
    while (bus.robot_clock !== 1'b1 && n < LIM) begin @(posedge clock); #1; n++; end
    check("resume_latency", n, 1);
    reset = 1'b0;
    #1;
    check("reset_in_high", {bus.robot_clock, bus.head, bus.left, bus.under, bus.barrier,
          bus.bump, bus.step_count, bus.rd_data, bus.robot_row, bus.robot_col,
          bus.robot_orient}, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    count_edges(3 * STEP_DIV, rises, falls);
    check("load_after_reset", rises, 0);

    // Random maps, poses and command streams.
    for (int k = 0; k < 6; k++) begin
      int v;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          v = $urandom_range(0, 19);
          m_map[r][c] = (v < 11) ? 0 : (v < 14) ? 1 : (v < 18) ? 2 : 7;
        end
      begin_scn($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), $urandom_range(0, 3));
      repeat (40) tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3) != 0);
      end_sb();
      read_map_check("map_random");
    end

    repeat (4) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
